// File: rtl/serial_nibble_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit (0).
// Recovered word is presented in parallel with one-cycle valid/error strobes.
module serial_nibble_receiver #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             framing_err,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_acc;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state <= IDLE;
    else if (enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (serial_in) state_nxt = DATA;
      DATA:    if (cnt == CNT_LAST) begin
                 if (PARITY_EN) state_nxt = PARITY;
                 else           state_nxt = STOP;
               end
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and strobes; strobes clear every edge regardless of enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      if (enable) begin
        case (state)
          IDLE: begin
            if (serial_in) begin
              cnt     <= '0;
              par_acc <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= shift_in(shreg, serial_in);
            par_acc <= par_acc ^ serial_in;
            cnt     <= cnt + CNT_W'(1);
          end
          PARITY: par_acc <= par_acc ^ serial_in;
          STOP: begin
            if (!serial_in) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              parity_err <= PARITY_EN & par_acc;
            end else begin
              framing_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
